// File: rtl/fetch_request_unit.sv
// rtl/fetch_request_unit.sv - multicycle fetch/data request sequencer with pcenable pulse
module fetch_request_unit #(
    parameter int          STALL_W  = 16,
    parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [31:0]        i_pc_addr,
    input  logic               i_ihit,
    input  logic [31:0]        i_iload,
    input  logic               i_dhit,
    input  logic               i_dren_req,
    input  logic               i_dwen_req,
    input  logic               i_halt_req,
    output logic               o_imemREN,
    output logic [31:0]        o_imemaddr,
    output logic               o_dmemREN,
    output logic               o_dmemWEN,
    output logic [31:0]        o_instr,
    output logic               o_instr_valid,
    output logic               o_pcenable,
    output logic               o_halt,
    output logic [STALL_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        DATA   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next_state;
    logic                r_run;
    logic                r_dren;
    logic                r_dwen;
    logic [31:0]         r_instr;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic                w_stall_inc;
    logic                w_pcenable;

    // r_run holds every request low for the first cycle after reset release
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            r_state     <= FETCH;
            r_run       <= 1'b0;
            r_dren      <= 1'b0;
            r_dwen      <= 1'b0;
            r_instr     <= RESET_IR;
            r_stall_cnt <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next_state;
            if (r_run && r_state == FETCH && i_ihit) begin
                r_instr <= i_iload;
            end
            // Load wins when decode flags both; the store is dropped
            if (r_state == EXEC) begin
                r_dren <= i_dren_req;
                r_dwen <= i_dwen_req & ~i_dren_req;
            end
            if (w_stall_inc && r_stall_cnt != {STALL_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + STALL_ONE;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pcenable   = 1'b0;
        w_stall_inc  = 1'b0;
        case (r_state)
            FETCH: begin
                if (r_run) begin
                    if (i_ihit) begin
                        w_next_state = EXEC;
                    end else begin
                        w_stall_inc = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (i_halt_req) begin
                    w_next_state = HALTED;
                end else if (i_dren_req || i_dwen_req) begin
                    w_next_state = DATA;
                end else begin
                    w_pcenable   = 1'b1;
                    w_next_state = FETCH;
                end
            end
            DATA: begin
                if (i_dhit) begin
                    w_pcenable   = 1'b1;
                    w_next_state = FETCH;
                end else begin
                    w_stall_inc = 1'b1;
                end
            end
            HALTED: begin
                w_next_state = HALTED;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    assign o_imemREN     = r_run && (r_state == FETCH);
    assign o_imemaddr    = i_pc_addr;
    assign o_dmemREN     = (r_state == DATA) && r_dren;
    assign o_dmemWEN     = (r_state == DATA) && r_dwen;
    assign o_instr       = r_instr;
    assign o_instr_valid = (r_state == EXEC) || (r_state == DATA);
    assign o_pcenable    = w_pcenable;
    assign o_halt        = (r_state == HALTED);
    assign o_stall_cnt   = r_stall_cnt;

endmodule
